// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared types and HD44780 command codes for the LCD sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [1:0] {
        PWRUP   = 2'd0,
        INIT    = 2'd1,
        IDLE    = 2'd2,
        REFRESH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PHY_IDLE  = 2'd0,
        PHY_SETUP = 2'd1,
        PHY_EN    = 2'd2,
        PHY_WAIT  = 2'd3
    } phy_state_t;

    localparam logic [7:0] CMD_FUNC    = 8'h38;
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_ROW0    = 8'h80;
    localparam logic [7:0] CMD_ROW1    = 8'hC0;
    localparam logic [7:0] CHAR_SPACE  = 8'h20;

    // Four init commands; a refresh is two row-address commands plus 32 chars
    localparam int N_INIT_CMDS = 4;
    localparam int N_WRITES    = 34;
    localparam int ROW1_STEP   = 17;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ctrl_if
// Description : Host request side and LCD pin side of the LCD sequencer.
//               master = character generator / board, slave = lcd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_ctrl_if;
    logic [255:0] i_string;
    logic         i_update;
    logic         o_ready;
    logic         o_done;
    logic [7:0]   o_LCD_DATA;
    logic         o_LCD_EN;
    logic         o_LCD_RS;
    logic         o_LCD_RW;
    logic         o_LCD_ON;

    modport master (
        output i_string, i_update,
        input  o_ready, o_done, o_LCD_DATA, o_LCD_EN, o_LCD_RS, o_LCD_RW, o_LCD_ON
    );

    modport slave (
        input  i_string, i_update,
        output o_ready, o_done, o_LCD_DATA, o_LCD_EN, o_LCD_RS, o_LCD_RW, o_LCD_ON
    );
endinterface
`default_nettype wire

// File: rtl/lcd_write_phy.sv
`default_nettype none
// ============================================================================
// Module      : lcd_write_phy
// Description : Performs one HD44780 byte write: 2 setup cycles, T_EN cycles
//               of EN high, then a post-write wait (T_CLEAR when i_long).
//               RS/DATA stay on the pins until the next write is started.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_write_phy
    import lcd_pkg::*;
#(
    parameter int T_EN    = 16,
    parameter int T_CMD   = 2000,
    parameter int T_CLEAR = 82000
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst_n,
    input  wire logic       i_start,
    input  wire logic       i_rs,
    input  wire logic [7:0] i_data,
    input  wire logic       i_long,
    output logic            o_busy,
    output logic            o_done,
    output logic [7:0]      o_lcd_data,
    output logic            o_lcd_en,
    output logic            o_lcd_rs
);

    localparam int SETUP_CYCLES = 2;
    // Floor of 4 keeps the counter at least 2 bits for tiny parameter sets
    localparam int CNT_MAX = max_of(max_of(T_EN, 4), max_of(T_CMD, T_CLEAR));
    localparam int CW      = $clog2(CNT_MAX);

    phy_state_t      state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, cnt_inc, wait_last;
    logic            long_q;
    logic            en_nxt;
    logic [7:0]      data_q;
    logic            rs_q;
    logic            en_q;

    assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
    assign wait_last = long_q ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);

    // Next-state, counter and enable decode for one byte write
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_inc;
        en_nxt    = 1'b0;
        o_done    = 1'b0;
        case (state)
            PHY_IDLE: begin
                cnt_nxt = '0;
                if (i_start) begin
                    state_nxt = PHY_SETUP;
                end
            end
            PHY_SETUP: begin
                if (cnt == CW'(SETUP_CYCLES - 1)) begin
                    state_nxt = PHY_EN;
                    cnt_nxt   = '0;
                    en_nxt    = 1'b1;
                end
            end
            PHY_EN: begin
                en_nxt = 1'b1;
                if (cnt == CW'(T_EN - 1)) begin
                    state_nxt = PHY_WAIT;
                    cnt_nxt   = '0;
                    en_nxt    = 1'b0;
                end
            end
            PHY_WAIT: begin
                if (cnt == wait_last) begin
                    state_nxt = PHY_IDLE;
                    cnt_nxt   = '0;
                    o_done    = 1'b1;
                end
            end
            default: state_nxt = PHY_IDLE;
        endcase
    end

    // State, counter and pin registers; reset drops EN immediately
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= PHY_IDLE;
            cnt    <= '0;
            long_q <= 1'b0;
            data_q <= 8'h00;
            rs_q   <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            en_q  <= en_nxt;
            if (state == PHY_IDLE && i_start) begin
                data_q <= i_data;
                rs_q   <= i_rs;
                long_q <= i_long;
            end
        end
    end

    assign o_busy     = (state != PHY_IDLE);
    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_en   = en_q;

endmodule
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ctrl
// Description : HD44780 16x2 sequencer: power-up wait, init command list,
//               then full-screen refreshes of a latched 32-character string.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = 750000,
    parameter int T_EN      = 16,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000
) (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    lcd_ctrl_if.slave bus
);

    localparam int CNT_MAX = max_of(max_of(T_POWERUP, 4), max_of(max_of(T_EN, T_CMD), T_CLEAR));
    localparam int CW      = $clog2(CNT_MAX);

    state_t         state, state_nxt;
    logic [CW-1:0]  pu_cnt, pu_cnt_nxt;
    logic [5:0]     step, step_nxt;
    logic [255:0]   latch, latch_nxt;
    logic           pending, pending_nxt;
    logic           done_q, done_nxt;
    logic           lcd_on;
    logic [4:0]     char_idx;

    logic           wr_start, wr_rs, wr_long, wr_busy, wr_done;
    logic [7:0]     wr_data;
    logic [7:0]     phy_data;
    logic           phy_en, phy_rs;

    // Step 1..16 address chars 0..15, step 18..33 address chars 16..31
    assign char_idx = (step < 6'(ROW1_STEP)) ? 5'(step - 6'd1) : 5'(step - 6'd2);

    // Byte for the current sequence step; a new write starts whenever the phy is free
    always_comb begin
        wr_start = 1'b0;
        wr_rs    = 1'b0;
        wr_data  = 8'h00;
        wr_long  = 1'b0;
        if (state == INIT) begin
            wr_start = !wr_busy;
            case (step[1:0])
                2'd0:    wr_data = CMD_FUNC;
                2'd1:    wr_data = CMD_DISP_ON;
                2'd2: begin
                    wr_data = CMD_CLEAR;
                    wr_long = 1'b1;
                end
                default: wr_data = CMD_ENTRY;
            endcase
        end else if (state == REFRESH) begin
            wr_start = !wr_busy;
            if (step == 6'd0) begin
                wr_data = CMD_ROW0;
            end else if (step == 6'(ROW1_STEP)) begin
                wr_data = CMD_ROW1;
            end else begin
                wr_rs   = 1'b1;
                wr_data = latch[{char_idx, 3'b000} +: 8];
            end
        end
    end

    // Sequencing FSM; a pending request skips IDLE and restarts REFRESH directly
    always_comb begin
        state_nxt   = state;
        pu_cnt_nxt  = pu_cnt;
        step_nxt    = step;
        latch_nxt   = latch;
        pending_nxt = pending | (bus.i_update && state != IDLE);
        done_nxt    = 1'b0;
        case (state)
            PWRUP: begin
                if (pu_cnt == CW'(T_POWERUP - 1)) begin
                    state_nxt = INIT;
                    step_nxt  = 6'd0;
                end else if (pu_cnt != '1) begin
                    pu_cnt_nxt = pu_cnt + 1'b1;
                end
            end
            INIT: begin
                if (wr_done) begin
                    if (step == 6'(N_INIT_CMDS - 1)) begin
                        state_nxt = REFRESH;
                        step_nxt  = 6'd0;
                        latch_nxt = {32{CHAR_SPACE}};
                    end else begin
                        step_nxt = step + 6'd1;
                    end
                end
            end
            IDLE: begin
                if (bus.i_update || pending) begin
                    state_nxt   = REFRESH;
                    step_nxt    = 6'd0;
                    latch_nxt   = bus.i_string;
                    pending_nxt = 1'b0;
                end
            end
            REFRESH: begin
                if (wr_done) begin
                    if (step == 6'(N_WRITES - 1)) begin
                        done_nxt = 1'b1;
                        step_nxt = 6'd0;
                        if (pending || bus.i_update) begin
                            latch_nxt   = bus.i_string;
                            pending_nxt = 1'b0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        step_nxt = step + 6'd1;
                    end
                end
            end
            default: state_nxt = PWRUP;
        endcase
    end

    // Controller state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= PWRUP;
            pu_cnt  <= '0;
            step    <= 6'd0;
            latch   <= '0;
            pending <= 1'b0;
            done_q  <= 1'b0;
            lcd_on  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pu_cnt  <= pu_cnt_nxt;
            step    <= step_nxt;
            latch   <= latch_nxt;
            pending <= pending_nxt;
            done_q  <= done_nxt;
            lcd_on  <= 1'b1;
        end
    end

    lcd_write_phy #(
        .T_EN    (T_EN),
        .T_CMD   (T_CMD),
        .T_CLEAR (T_CLEAR)
    ) u_phy (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (wr_start),
        .i_rs       (wr_rs),
        .i_data     (wr_data),
        .i_long     (wr_long),
        .o_busy     (wr_busy),
        .o_done     (wr_done),
        .o_lcd_data (phy_data),
        .o_lcd_en   (phy_en),
        .o_lcd_rs   (phy_rs)
    );

    assign bus.o_ready    = (state == IDLE);
    assign bus.o_done     = done_q;
    assign bus.o_LCD_DATA = phy_data;
    assign bus.o_LCD_EN   = phy_en;
    assign bus.o_LCD_RS   = phy_rs;
    assign bus.o_LCD_RW   = 1'b0;
    assign bus.o_LCD_ON   = lcd_on;

endmodule
`default_nettype wire
